// File: rtl/mem_intf_demux_ot.sv
// mem_intf_demux_ot
// Multi-outstanding TCDM demultiplexer. One master port is routed to
// NR_OUTPUTS slave ports by an address-map rule table; the selected slave sees
// the address rebased by the matched rule's start address. Up to
// MAX_OUTSTANDING reads may be in flight, all to the same slave. A request to
// a different slave waits until every pending response has returned, which
// keeps responses in order without a reorder buffer.
//
// Optional build macro: MEM_DEMUX_DECERR_EN
//   defined   : unmapped addresses go to an internal error port (index
//               NR_OUTPUTS) that grants at once, answers reads with 32'hBADCAB1E,
//               drops writes, and pulses err_o for each unmapped grant.
//   undefined : unmapped addresses go to port 0 unrebased; no err_o port.
//
// Ports (the mem_intf bundles are flattened to master_* / slave_* signals):
//   clk_i, reset_i      clock, synchronous active-high reset
//   master_*            upstream request/response (req, gnt, addr, wen, data,
//                       be, r_ready, r_valid, r_data)
//   slave_*[NR_OUTPUTS] downstream ports with the same fields
//   err_o               unmapped-grant pulse (MEM_DEMUX_DECERR_EN only)

package mem_pkg;
   typedef struct packed {
      logic [31:0] idx;
      logic [63:0] start_addr;
      logic [63:0] end_addr;   // exclusive
   } addr_map_rule_t;
endpackage

module mem_intf_demux_ot #(
   parameter int unsigned NR_OUTPUTS        = 2,
   parameter int unsigned NR_ADDR_MAP_RULES = 1,
   parameter mem_pkg::addr_map_rule_t [NR_ADDR_MAP_RULES-1:0] addr_map_rules = '0,
   parameter int unsigned ADDR_WIDTH        = 32,
   parameter int unsigned DATA_WIDTH        = 32,
   parameter int unsigned BE_WIDTH          = DATA_WIDTH/8,
   parameter int unsigned MAX_OUTSTANDING   = 4
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic                                   master_req,
   output logic                                   master_gnt,
   input  logic [ADDR_WIDTH-1:0]                  master_addr,
   input  logic                                   master_wen,
   input  logic [DATA_WIDTH-1:0]                  master_data,
   input  logic [BE_WIDTH-1:0]                    master_be,
   input  logic                                   master_r_ready,
   output logic                                   master_r_valid,
   output logic [DATA_WIDTH-1:0]                  master_r_data,
   output logic [NR_OUTPUTS-1:0]                  slave_req,
   input  logic [NR_OUTPUTS-1:0]                  slave_gnt,
   output logic [NR_OUTPUTS-1:0][ADDR_WIDTH-1:0]  slave_addr,
   output logic [NR_OUTPUTS-1:0]                  slave_wen,
   output logic [NR_OUTPUTS-1:0][DATA_WIDTH-1:0]  slave_data,
   output logic [NR_OUTPUTS-1:0][BE_WIDTH-1:0]    slave_be,
   output logic [NR_OUTPUTS-1:0]                  slave_r_ready,
   input  logic [NR_OUTPUTS-1:0]                  slave_r_valid,
   input  logic [NR_OUTPUTS-1:0][DATA_WIDTH-1:0]  slave_r_data
`ifdef MEM_DEMUX_DECERR_EN
   ,
   output logic                                   err_o
`endif
);

`ifdef MEM_DEMUX_DECERR_EN
   // one extra index for the internal error port
   localparam int unsigned PORT_W = $clog2(NR_OUTPUTS + 1);
`else
   localparam int unsigned PORT_W = (NR_OUTPUTS > 1) ? $clog2(NR_OUTPUTS) : 1;
`endif
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [CNT_W-1:0]      out_cnt;
   logic [PORT_W-1:0]     active_q;

   logic [PORT_W-1:0]     port_sel;
   logic                  rule_hit;
   logic [ADDR_WIDTH-1:0] hit_start;
   logic [ADDR_WIDTH-1:0] rebase;
   logic                  sel_gnt;
   logic                  act_r_valid;
   logic [DATA_WIDTH-1:0] act_r_data;
   logic                  retire;
   logic                  issue;
   logic                  granted;

   // Address decode: the last matching rule wins.
   always_comb begin
      logic [ADDR_WIDTH-1:0] r_start;
      logic [ADDR_WIDTH-1:0] r_end;
      rule_hit  = 1'b0;
      port_sel  = '0;
      hit_start = '0;
      for (int r = 0; r < int'(NR_ADDR_MAP_RULES); r++) begin
         r_start = addr_map_rules[r].start_addr[ADDR_WIDTH-1:0];
         r_end   = addr_map_rules[r].end_addr[ADDR_WIDTH-1:0];
         if (master_addr >= r_start && master_addr < r_end) begin
            rule_hit  = 1'b1;
            port_sel  = PORT_W'(addr_map_rules[r].idx);
            hit_start = r_start;
         end
      end
`ifdef MEM_DEMUX_DECERR_EN
      if (!rule_hit) port_sel = PORT_W'(NR_OUTPUTS);
`endif
   end

   assign rebase = rule_hit ? hit_start : '0;

   // Response mux from the slave owning the outstanding reads.
   always_comb begin
      act_r_valid = 1'b0;
      act_r_data  = '0;
      for (int p = 0; p < int'(NR_OUTPUTS); p++) begin
         if (active_q == PORT_W'(p)) begin
            act_r_valid = slave_r_valid[p];
            act_r_data  = slave_r_data[p];
         end
      end
`ifdef MEM_DEMUX_DECERR_EN
      // error port: its pending count is out_cnt, so it is always ready to answer
      if (active_q == PORT_W'(NR_OUTPUTS)) begin
         act_r_valid = 1'b1;
         act_r_data  = DATA_WIDTH'(32'hBADCAB1E);
      end
`endif
   end

   assign master_r_valid = (out_cnt != '0) && act_r_valid;
   assign master_r_data  = (out_cnt != '0) ? act_r_data : '0;
   assign retire         = master_r_valid && master_r_ready;

   // A full counter may still accept a read to the same slave when a response
   // retires in the same cycle.
   assign issue = master_req &&
                  ((out_cnt == '0) ||
                   ((port_sel == active_q) && ((out_cnt < CNT_MAX) || retire)));

   always_comb begin
      sel_gnt = 1'b0;
      for (int p = 0; p < int'(NR_OUTPUTS); p++) begin
         if (port_sel == PORT_W'(p)) sel_gnt = slave_gnt[p];
      end
`ifdef MEM_DEMUX_DECERR_EN
      if (port_sel == PORT_W'(NR_OUTPUTS)) sel_gnt = 1'b1;
`endif
   end

   assign master_gnt = issue && sel_gnt;
   assign granted    = master_gnt;

`ifdef MEM_DEMUX_DECERR_EN
   assign err_o = granted && !rule_hit;
`endif

   always_comb begin
      slave_req  = '0;
      slave_wen  = '1;
      slave_addr = '0;
      slave_data = '0;
      slave_be   = '0;
      for (int p = 0; p < int'(NR_OUTPUTS); p++) begin
         if (master_req && port_sel == PORT_W'(p)) begin
            slave_req[p]  = issue;
            slave_wen[p]  = master_wen;
            slave_addr[p] = master_addr - rebase;
            slave_data[p] = master_data;
            slave_be[p]   = master_be;
         end
      end
   end

   always_comb begin
      slave_r_ready = '0;
      for (int p = 0; p < int'(NR_OUTPUTS); p++) begin
         if (out_cnt != '0 && active_q == PORT_W'(p)) slave_r_ready[p] = master_r_ready;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         out_cnt  <= '0;
         active_q <= '0;
      end else begin
         case ({granted && !master_wen, retire})
            2'b10:   out_cnt <= out_cnt + CNT_W'(1);
            2'b01:   out_cnt <= out_cnt - CNT_W'(1);
            default: out_cnt <= out_cnt;
         endcase
         if (granted && (!master_wen || out_cnt == '0)) active_q <= port_sel;
      end
   end

   a_cnt_bound: assert property (@(posedge clk_i) disable iff (reset_i)
                                 out_cnt <= CNT_MAX);
   a_gnt_req:   assert property (@(posedge clk_i) disable iff (reset_i)
                                 master_gnt |-> master_req);

endmodule

// File: tb/tb_mem_intf_demux_ot.sv
module tb_mem_intf_demux_ot;

   localparam mem_pkg::addr_map_rule_t R0 = '{idx: 32'd0, start_addr: 64'h0000, end_addr: 64'h1000};
   localparam mem_pkg::addr_map_rule_t R1 = '{idx: 32'd1, start_addr: 64'h1000, end_addr: 64'h2000};
   localparam mem_pkg::addr_map_rule_t R2 = '{idx: 32'd1, start_addr: 64'h3000, end_addr: 64'h4000};
   localparam mem_pkg::addr_map_rule_t [2:0] RULES = {R2, R1, R0};

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic              master_req, master_gnt, master_wen, master_r_ready, master_r_valid;
   logic [31:0]       master_addr, master_data, master_r_data;
   logic [3:0]        master_be;
   logic [1:0]        slave_req, slave_gnt, slave_wen, slave_r_ready, slave_r_valid;
   logic [1:0][31:0]  slave_addr, slave_data, slave_r_data;
   logic [1:0][3:0]   slave_be;
`ifdef MEM_DEMUX_DECERR_EN
   logic              err_o;
`endif

   mem_intf_demux_ot #(
      .NR_OUTPUTS(2), .NR_ADDR_MAP_RULES(3), .addr_map_rules(RULES),
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .MAX_OUTSTANDING(4)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .master_req(master_req), .master_gnt(master_gnt), .master_addr(master_addr),
      .master_wen(master_wen), .master_data(master_data), .master_be(master_be),
      .master_r_ready(master_r_ready), .master_r_valid(master_r_valid),
      .master_r_data(master_r_data),
      .slave_req(slave_req), .slave_gnt(slave_gnt), .slave_addr(slave_addr),
      .slave_wen(slave_wen), .slave_data(slave_data), .slave_be(slave_be),
      .slave_r_ready(slave_r_ready), .slave_r_valid(slave_r_valid),
      .slave_r_data(slave_r_data)
`ifdef MEM_DEMUX_DECERR_EN
      , .err_o(err_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          port;
      int          due;
      logic [31:0] data;
   } sresp_t;

   sresp_t      sq[$];      // slave model: pending responses
   logic [31:0] exp_q[$];   // master-side expected read data
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_cyc;
   int          resp_delay = 3;
   logic [1:0]  spur = 2'b00;

   logic             mon_gnt, mon_retire;
   logic [1:0]       s_req, s_wen, s_rready, s_srvalid;
   logic [1:0][31:0] s_addr, s_data;
   logic [1:0][3:0]  s_be;
   logic             s_gnt, s_rvalid, s_err;
   logic [31:0]      s_rdata;

   function automatic logic [31:0] resp_word(input int p, input logic [31:0] a);
      return 32'hC000_0000 | (32'(p) << 20) | (a & 32'h0000_FFFF);
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      if (a < 32'h1000) return resp_word(0, a);
      if (a >= 32'h1000 && a < 32'h2000) return resp_word(1, a - 32'h1000);
      if (a >= 32'h3000 && a < 32'h4000) return resp_word(1, a - 32'h3000);
`ifdef MEM_DEMUX_DECERR_EN
      return 32'hBADCAB1E;
`else
      return resp_word(0, a);
`endif
   endfunction

   // One clock cycle: sample just before the rising edge, update models,
   // then advance to the falling edge and present new slave responses.
   task automatic tick();
      sresp_t e;
      bit     found;
      #4;
      last_cyc  = cyc;
      s_req     = slave_req;   s_wen = slave_wen;   s_addr = slave_addr;
      s_data    = slave_data;  s_be  = slave_be;    s_rready = slave_r_ready;
      s_srvalid = slave_r_valid;
      s_gnt     = master_gnt;  s_rvalid = master_r_valid; s_rdata = master_r_data;
`ifdef MEM_DEMUX_DECERR_EN
      s_err     = err_o;
`else
      s_err     = 1'b0;
`endif
      mon_gnt    = master_req && master_gnt;
      mon_retire = master_r_valid && master_r_ready;
      if (!reset_i) begin
         n_cmp++;
         if ($unsigned(dut.out_cnt) !== 32'(exp_q.size())) begin
            n_err++;
            $display("FAIL out_cnt @%0d: got %0d want %0d", cyc, dut.out_cnt, exp_q.size());
         end
      end
      if (mon_retire) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rsp_unexpected @%0d: got r_data %h want no response", cyc, master_r_data);
         end else begin
            if (master_r_data !== exp_q[0]) begin
               n_err++;
               $display("FAIL rsp_data @%0d: got %h want %h", cyc, master_r_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
      if (mon_gnt && !master_wen) exp_q.push_back(exp_word(master_addr));
      if (reset_i) exp_q.delete();
      for (int p = 0; p < 2; p++) begin
         if (slave_r_valid[p] && slave_r_ready[p]) begin
            for (int i = 0; i < sq.size(); i++) begin
               if (sq[i].port == p) begin
                  sq.delete(i);
                  break;
               end
            end
         end
         if (slave_req[p] && slave_gnt[p] && !slave_wen[p]) begin
            e.port = p;
            e.due  = cyc + resp_delay;
            e.data = resp_word(p, slave_addr[p]);
            sq.push_back(e);
         end
      end
      @(negedge clk_i);
      cyc++;
      for (int p = 0; p < 2; p++) begin
         slave_r_valid[p] = spur[p];
         slave_r_data[p]  = '0;
         found = 1'b0;
         for (int i = 0; i < sq.size(); i++) begin
            if (!found && sq[i].port == p) begin
               found = 1'b1;
               if (cyc >= sq[i].due) begin
                  slave_r_valid[p] = 1'b1;
                  slave_r_data[p]  = sq[i].data;
               end
            end
         end
      end
   endtask

   task automatic drive_read(input logic [31:0] a);
      master_req = 1'b1; master_wen = 1'b0; master_addr = a;
      master_data = '0; master_be = 4'hF;
   endtask

   task automatic drain();
      int n = 0;
      master_req = 1'b0;
      master_r_ready = 1'b1;
      while (exp_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      tick();
      tick();
      reset_i = 1'b0;
      tick();
      n_cmp++; if (s_req !== 2'b00) begin n_err++; $display("FAIL rst_req: got %b want 00", s_req); end
      n_cmp++; if (s_wen !== 2'b11) begin n_err++; $display("FAIL rst_wen: got %b want 11", s_wen); end
      n_cmp++; if (s_gnt !== 1'b0) begin n_err++; $display("FAIL rst_gnt: got %b want 0", s_gnt); end
      n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b want 0", s_rvalid); end
      n_cmp++; if (s_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", s_rdata); end
      n_cmp++; if (s_rready !== 2'b00) begin n_err++; $display("FAIL rst_rready: got %b want 00", s_rready); end
   endtask

   task automatic test_back_to_back();
      int g[5];
      int k = 0;
      int n = 0;
      int first_ret = -1;
      for (int i = 0; i < 5; i++) g[i] = -1;
      resp_delay = 5; slave_gnt = 2'b11; master_r_ready = 1'b1;
      while (k < 5 && n < 40) begin
         drive_read(32'h1004 + 32'(4 * k));
         tick();
         n++;
         n_cmp++;
         if (s_addr[1] !== master_addr - 32'h1000) begin
            n_err++;
            $display("FAIL b2b_addr: got %h want %h", s_addr[1], master_addr - 32'h1000);
         end
         if (mon_retire && first_ret < 0) first_ret = last_cyc;
         if (mon_gnt) begin
            g[k] = last_cyc;
            k++;
         end else begin
            n_cmp++;
            if (s_req[1] !== 1'b0) begin n_err++; $display("FAIL b2b_stall_req: got %b want 0", s_req[1]); end
         end
      end
      master_req = 1'b0;
      n_cmp++; if (k != 5) begin n_err++; $display("FAIL b2b_timeout: got %0d grants want 5", k); end
      for (int i = 1; i < 4; i++) begin
         n_cmp++;
         if (g[i] != g[0] + i) begin n_err++; $display("FAIL b2b_consec%0d: got cycle %0d want %0d", i, g[i], g[0] + i); end
      end
      n_cmp++; if (first_ret != g[0] + 5) begin n_err++; $display("FAIL b2b_first_rsp: got cycle %0d want %0d", first_ret, g[0] + 5); end
      n_cmp++; if (g[4] != first_ret) begin n_err++; $display("FAIL b2b_fifth_gnt: got cycle %0d want %0d", g[4], first_ret); end
      drain();
   endtask

   task automatic test_switch_port();
      int ga = -1, gb = -1, ret = -1, n = 0;
      resp_delay = 3; slave_gnt = 2'b11; master_r_ready = 1'b1;
      drive_read(32'h0000_0040);
      tick();
      if (mon_gnt) ga = last_cyc;
      n_cmp++; if (ga < 0) begin n_err++; $display("FAIL sw_gnt0: got 0 want 1"); end
      drive_read(32'h0000_1020);
      while (gb < 0 && n < 20) begin
         tick();
         n++;
         if (mon_retire) ret = last_cyc;
         if (mon_gnt) gb = last_cyc;
         else begin
            n_cmp++;
            if (s_req[1] !== 1'b0) begin n_err++; $display("FAIL sw_req1_held: got %b want 0", s_req[1]); end
         end
      end
      master_req = 1'b0;
      n_cmp++; if (ret != ga + 3) begin n_err++; $display("FAIL sw_retire: got cycle %0d want %0d", ret, ga + 3); end
      n_cmp++; if (gb != ret + 1) begin n_err++; $display("FAIL sw_gnt1: got cycle %0d want %0d", gb, ret + 1); end
      drain();
   endtask

   task automatic test_backpressure();
      int n = 0;
      resp_delay = 2; slave_gnt = 2'b11; master_r_ready = 1'b0;
      drive_read(32'h0000_1100);
      tick();
      n_cmp++; if (!mon_gnt) begin n_err++; $display("FAIL bp_gnt: got 0 want 1"); end
      master_req = 1'b0;
      while (!s_rvalid && n < 10) begin tick(); n++; end
      n_cmp++; if (!s_rvalid) begin n_err++; $display("FAIL bp_rvalid_timeout: got 0 want 1"); end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (s_rvalid !== 1'b1 || exp_q.size() != 1 || s_rdata !== exp_q[0]) begin
            n_err++;
            $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=%h", i, s_rvalid, s_rdata, resp_word(1, 32'h100));
         end
      end
      master_r_ready = 1'b1;
      tick();
      n_cmp++; if (!mon_retire) begin n_err++; $display("FAIL bp_retire: got 0 want 1"); end
      tick();
      n_cmp++; if (dut.out_cnt !== 3'd0) begin n_err++; $display("FAIL bp_cnt_after: got %0d want 0", dut.out_cnt); end
   endtask

   task automatic test_write_and_rule_index();
      slave_gnt = 2'b01; master_r_ready = 1'b1;
      master_req = 1'b1; master_wen = 1'b1; master_addr = 32'h1008;
      master_data = 32'hCAFE_F00D; master_be = 4'b0101;
      tick();
      n_cmp++; if (s_gnt !== 1'b0) begin n_err++; $display("FAIL wr_no_slave_gnt: got %b want 0", s_gnt); end
      slave_gnt = 2'b11;
      tick();
      n_cmp++; if (s_gnt !== 1'b1) begin n_err++; $display("FAIL wr_gnt: got %b want 1", s_gnt); end
      n_cmp++; if (s_req !== 2'b10 || s_wen !== 2'b11) begin n_err++; $display("FAIL wr_req_wen: got %b/%b want 10/11", s_req, s_wen); end
      n_cmp++; if (s_addr[1] !== 32'h8 || s_data[1] !== 32'hCAFE_F00D || s_be[1] !== 4'b0101) begin
         n_err++; $display("FAIL wr_fields: got %h %h %b want 8 cafef00d 0101", s_addr[1], s_data[1], s_be[1]);
      end
      n_cmp++; if (s_addr[0] !== 32'h0 || s_be[0] !== 4'h0) begin n_err++; $display("FAIL wr_idle0: got %h %b want 0 0", s_addr[0], s_be[0]); end
      drive_read(32'h0000_3010);
      tick();
      n_cmp++; if (s_req !== 2'b10 || s_addr[1] !== 32'h10) begin
         n_err++; $display("FAIL rule_idx: got req=%b addr=%h want 10 00000010", s_req, s_addr[1]);
      end
      drain();
   endtask

   task automatic test_unmapped();
      resp_delay = 2; slave_gnt = 2'b11; master_r_ready = 1'b1;
      drive_read(32'hFFFF_0000);
      tick();
`ifdef MEM_DEMUX_DECERR_EN
      n_cmp++; if (s_gnt !== 1'b1 || s_req !== 2'b00) begin n_err++; $display("FAIL decerr_gnt: got gnt=%b req=%b want 1 00", s_gnt, s_req); end
      n_cmp++; if (s_err !== 1'b1) begin n_err++; $display("FAIL decerr_err: got %b want 1", s_err); end
      master_req = 1'b0;
      tick();
      n_cmp++; if (s_rvalid !== 1'b1 || s_rdata !== 32'hBADCAB1E) begin n_err++; $display("FAIL decerr_rsp: got %b %h want 1 badcab1e", s_rvalid, s_rdata); end
      n_cmp++; if (s_err !== 1'b0) begin n_err++; $display("FAIL decerr_err_pulse: got %b want 0", s_err); end
`else
      n_cmp++; if (s_req !== 2'b01 || s_addr[0] !== 32'hFFFF_0000) begin
         n_err++; $display("FAIL unmapped_route: got req=%b addr=%h want 01 ffff0000", s_req, s_addr[0]);
      end
      n_cmp++; if (s_err !== 1'b0) begin n_err++; $display("FAIL unmapped_err: got %b want 0", s_err); end
`endif
      drain();
   endtask

   task automatic test_reset_midop();
      int k = 0, n = 0, seen = 0;
      resp_delay = 6; slave_gnt = 2'b11; master_r_ready = 1'b1;
      while (k < 3 && n < 20) begin
         drive_read(32'h10 + 32'(4 * k));
         tick();
         n++;
         if (mon_gnt) k++;
      end
      master_req = 1'b0;
      n_cmp++; if (k != 3) begin n_err++; $display("FAIL rmid_issue: got %0d grants want 3", k); end
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (s_srvalid[0]) seen++;
         n_cmp++;
         if (s_rvalid !== 1'b0 || s_rready !== 2'b00) begin
            n_err++; $display("FAIL rmid_fwd @%0d: got rvalid=%b rready=%b want 0 00", last_cyc, s_rvalid, s_rready);
         end
      end
      n_cmp++; if (seen == 0) begin n_err++; $display("FAIL rmid_stim: got 0 stale slave responses want >0"); end
      sq.delete();
      slave_r_valid = 2'b00;
      slave_r_data  = '0;
      tick();
   endtask

   initial begin
      reset_i = 1'b1;
      master_req = 1'b0; master_wen = 1'b1; master_addr = '0; master_data = '0;
      master_be = '0; master_r_ready = 1'b0;
      slave_gnt = 2'b00; slave_r_valid = 2'b00; slave_r_data = '0;
      @(negedge clk_i);
      test_reset();
      test_back_to_back();
      test_switch_port();
      test_backpressure();
      test_write_and_rule_index();
      test_unmapped();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
